muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op encodings,
// FSM state encoding and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational two's-complement helper: passes the value through or negates it.
// Used both to take operand magnitudes and to restore result signs.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign result_o = neg_i ? (~value_i + ONE) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: sign-magnitude iteration over WIDTH
// cycles, a one-cycle sign fix-up, then results land in HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  // res_sign: sign of product/quotient; rem_sign: sign of remainder (dividend's).
  logic               res_sign_q, res_sign_d;
  logic               rem_sign_q, rem_sign_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [WIDTH-1:0]   work_hi_q, work_hi_d;
  logic [WIDTH-1:0]   work_lo_q, work_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;

  logic               accept;
  logic               op_signed, op_div, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign op_signed = op_is_signed(op);
  assign op_div    = op_is_div(op);
  assign b_zero    = (b == '0);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .value_i  (a),
    .neg_i    (op_signed & a[WIDTH-1]),
    .result_o (abs_a)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .value_i  (b),
    .neg_i    (op_signed & b[WIDTH-1]),
    .result_o (abs_b)
  );

  // Multiply step: low half holds the remaining multiplier bits, upper half
  // accumulates; the carry out of the add shifts into the top of the product.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
  assign mul_next = {mul_sum, work_lo_q[WIDTH-1:1]};

  // Restoring divide step: the partial remainder stays below the divisor, so
  // the (WIDTH+1)-bit difference's MSB is a clean borrow flag.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next, div_quo_next;

  assign div_shift    = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, operand_q};
  assign div_ge       = ~div_diff[WIDTH];
  assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_next = {work_lo_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value_i  ({work_hi_q, work_lo_q}),
    .neg_i    (res_sign_q),
    .result_o (prod_fixed)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .value_i  (work_lo_q),
    .neg_i    (res_sign_q),
    .result_o (quo_fixed)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value_i  (work_hi_q),
    .neg_i    (rem_sign_q),
    .result_o (rem_fixed)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    res_sign_d = res_sign_q;
    rem_sign_d = rem_sign_q;
    operand_d  = operand_q;
    work_hi_d  = work_hi_q;
    work_lo_d  = work_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          is_div_d   = op_div;
          res_sign_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_sign_d = op_signed & a[WIDTH-1];
          div_zero_d = op_div & b_zero;
          cnt_d      = CNT_W'(WIDTH);
          operand_d  = op_div ? abs_b : abs_a;
          work_hi_d  = '0;
          work_lo_d  = op_div ? abs_a : abs_b;
          if (op_div && b_zero) begin
            state_d = S_DONE;
          end else begin
            state_d = op_div ? S_DIV : S_MUL;
          end
        end
      end

      S_MUL: begin
        {work_hi_d, work_lo_d} = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end

      S_DIV: begin
        work_hi_d = div_rem_next;
        work_lo_d = div_quo_next;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end else begin
          {hi_d, lo_d} = prod_fixed;
        end
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      res_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      operand_q  <= '0;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      res_sign_q <= res_sign_d;
      rem_sign_q <= rem_sign_d;
      operand_q  <= operand_d;
      work_hi_q  <= work_hi_d;
      work_lo_q  <= work_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  // Expected architectural HI/LO as tracked by the bench.
  logic [W-1:0] exp_hi, exp_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact 64-bit arithmetic; returns {hi, lo}. b must be nonzero for divides.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, rm;
    logic [63:0] ux, uy, r;
    sx = $signed(x);
    sy = $signed(y);
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = ux * uy;
      OP_DIV: begin
        q  = sx / sy;
        rm = sx % sy;
        r  = {rm[31:0], q[31:0]};
      end
      default: r = {x % y, x / y};
    endcase
    return r;
  endfunction

  // Issue one op and wait for done. Cycle 0 is the accept cycle. When poke_cyc
  // is nonzero, a stray start is driven during that busy cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit no_wait, input int poke_cyc,
                       output int done_cyc, output bit busy_ok, output bit hold_ok);
    if (!no_wait) @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      if (c == poke_cyc) begin
        start = 1'b1; op = OP_DIVU; a = $urandom; b = '0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = OP_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (hi !== '0 || lo !== '0) begin miscompares++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_mult_latency();
    int dc; bit bok, hok;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, dc, bok, hok);
    vectors++; if (dc !== LAT) begin miscompares++; $display("FAIL mult_latency: got %0d want %0d", dc, LAT); end
    vectors++; if (!bok) begin miscompares++; $display("FAIL mult_busy: got busy low in cycles 1..%0d want high", LAT - 1); end
    vectors++; if (!hok) begin miscompares++; $display("FAIL mult_hold: got hi/lo changing while busy want stable"); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
  endtask

  task automatic test_multu_ignore_start();
    int dc; bit bok, hok;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10, dc, bok, hok);
    vectors++; if (dc !== LAT) begin miscompares++; $display("FAIL multu_latency: got %0d want %0d", dc, LAT); end
    vectors++; if (!bok) begin miscompares++; $display("FAIL multu_busy: got busy low before done want high"); end
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL multu_dz: got %b want 0", div_zero); end
    exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL multu_after_done: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_div();
    int dc; bit bok, hok;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, dc, bok, hok);
    vectors++; if (dc !== LAT) begin miscompares++; $display("FAIL div_latency: got %0d want %0d", dc, LAT); end
    vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_quo: got %h want fffffffd", lo); end
    vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_rem: got %h want ffffffff", hi); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 0, dc, bok, hok);
    vectors++; if (!hok) begin miscompares++; $display("FAIL divu_hold: got hi/lo changing while busy want stable"); end
    vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_quo: got %0d want 14", lo); end
    vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_rem: got %0d want 2", hi); end
    exp_hi = 32'd2; exp_lo = 32'd14;
  endtask

  task automatic test_div_zero();
    int dc; bit bok, hok;
    issue(OP_DIVU, 32'd100, 32'd0, 1'b0, 0, dc, bok, hok);
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL dz_latency: got %0d want 1", dc); end
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    vectors++; if (hi !== 32'd2 || lo !== 32'd14) begin miscompares++; $display("FAIL dz_hilo: got %h_%h want 00000002_0000000e", hi, lo); end
    @(negedge clk);
    vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_sticky: got %b want 1", div_zero); end
    issue(OP_MULT, 32'd2, 32'd3, 1'b0, 0, dc, bok, hok);
    vectors++; if (dc !== LAT) begin miscompares++; $display("FAIL dz_clear_latency: got %0d want %0d", dc, LAT); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL dz_clear: got %b want 0", div_zero); end
    vectors++; if (hi !== 32'd0 || lo !== 32'd6) begin miscompares++; $display("FAIL dz_clear_hilo: got %h_%h want 00000000_00000006", hi, lo); end
    exp_hi = 32'd0; exp_lo = 32'd6;
  endtask

  task automatic test_back_to_back();
    int dc; bit bok, hok;
    logic [W-1:0] x, y;
    logic [63:0] r;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, dc, bok, hok);
    vectors++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin miscompares++; $display("FAIL minneg1_hilo: got %h_%h want 00000000_80000000", hi, lo); end
    vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL minneg1_dz: got %b want 0", div_zero); end
    exp_hi = 32'd0; exp_lo = 32'h8000_0000;
    x = $urandom; y = $urandom;
    r = model(OP_MULTU, x, y);
    issue(OP_MULTU, x, y, 1'b1, 0, dc, bok, hok);
    vectors++; if (dc !== LAT) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", dc, LAT); end
    vectors++; if ({hi, lo} !== r) begin miscompares++; $display("FAIL b2b_result: got %h_%h want %h", hi, lo, r); end
    exp_hi = r[63:32]; exp_lo = r[31:0];
  endtask

  task automatic test_reset_mid_op();
    int dc; bit bok, hok, seen;
    logic [W-1:0] x, y;
    logic [63:0] r;
    @(negedge clk);
    op = OP_DIV; a = $urandom; b = $urandom | 32'h1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    vectors++; if (hi !== '0 || lo !== '0) begin miscompares++; $display("FAIL midrst_hilo: got %h_%h want 0_0", hi, lo); end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 8; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL midrst_no_done: got activity after reset want idle"); end
    x = $urandom; y = $urandom;
    r = model(OP_MULT, x, y);
    issue(OP_MULT, x, y, 1'b0, 0, dc, bok, hok);
    vectors++; if (dc !== LAT || {hi, lo} !== r) begin miscompares++; $display("FAIL midrst_restart: got cyc=%0d %h_%h want cyc=%0d %h", dc, hi, lo, LAT, r); end
    exp_hi = r[63:32]; exp_lo = r[31:0];
  endtask

  task automatic test_random();
    int dc; bit bok, hok, nw;
    logic [1:0] o;
    logic [W-1:0] x, y;
    logic [63:0] r;
    bit dz;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: y = '1;
        3: x = 32'h8000_0000;
        default: ;
      endcase
      nw = (i > 0) && ($urandom_range(0, 3) == 0);
      dz = o[1] && (y == '0);
      r  = dz ? {exp_hi, exp_lo} : model(o, x, y);
      issue(o, x, y, nw, 0, dc, bok, hok);
      vectors++; if (dc !== (dz ? 1 : LAT)) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, dc, dz ? 1 : LAT); end
      vectors++; if ({hi, lo} !== r) begin miscompares++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h_%h want %h", i, o, x, y, hi, lo, r); end
      vectors++; if (div_zero !== dz) begin miscompares++; $display("FAIL rnd_dz[%0d]: got %b want %b", i, div_zero, dz); end
      if (!dz) begin
        vectors++; if (!bok || !hok) begin miscompares++; $display("FAIL rnd_busy_hold[%0d]: got busy_ok=%b hold_ok=%b want 1 1", i, bok, hok); end
      end
      exp_hi = r[63:32]; exp_lo = r[31:0];
    end
  endtask

  initial begin
    test_reset();
    test_mult_latency();
    test_multu_ignore_start();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
